// File: rtl/delay_pkg.sv
// Shared helpers for the programmable delay line: the delay clamp.
package delay_pkg;

  // Working width of the clamp helper; callers zero-extend in and truncate out.
  localparam int DLY_FW = 16;

  // Map a requested delay onto the legal range 1..max.
  function automatic logic [DLY_FW-1:0] clamp_delay(input logic [DLY_FW-1:0] req,
                                                    input logic [DLY_FW-1:0] max);
    if (req == '0)      return DLY_FW'(1);
    else if (req > max) return max;
    else                return req;
  endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// Combinational MAX_DELAY:1 tap select of {valid,data}; sel = active delay - 1.
module delay_tap_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DELAY  = 16,
  parameter int CNT_W      = 5
) (
  input  logic [MAX_DELAY-1:0]                 tap_valid,
  input  logic [MAX_DELAY-1:0][DATA_WIDTH-1:0] tap_data,
  input  logic [CNT_W-1:0]                     sel,
  output logic                                 o_valid,
  output logic [DATA_WIDTH-1:0]                o_data
);

  // Compare-and-select so the sel width never has to match the array index width.
  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (sel == CNT_W'(k)) begin
        o_valid = tap_valid[k];
        o_data  = tap_data[k];
      end
    end
  end

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line with valid tracking, stall and flush-on-load.
module prog_delay_line
  import delay_pkg::*;
#(
  parameter  int DATA_WIDTH    = 8,
  parameter  int MAX_DELAY     = 16,
  parameter  int DEFAULT_DELAY = 4,
  localparam int CNT_W         = $clog2(MAX_DELAY + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_delay_load,
  input  logic [CNT_W-1:0]      i_delay,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_W-1:0]      o_delay,
  output logic                  o_fill
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  localparam logic [CNT_W-1:0] DLY_RST = CNT_W'(DEFAULT_DELAY);

  stage_t [MAX_DELAY-1:0]                 stg;
  logic   [MAX_DELAY-1:0]                 vld_pipe;
  logic   [MAX_DELAY-1:0][DATA_WIDTH-1:0] tap_data;
  logic   [CNT_W-1:0]                     dly_q;
  logic   [CNT_W-1:0]                     dly_new;
  logic   [CNT_W-1:0]                     fill_cnt;

  assign dly_new = CNT_W'(clamp_delay(DLY_FW'(i_delay), DLY_FW'(MAX_DELAY)));

  // Stage array: load clears valids (data kept, input dropped), else shift when enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stg <= '0;
    end else if (i_delay_load) begin
      for (int k = 0; k < MAX_DELAY; k++) stg[k].valid <= 1'b0;
    end else if (i_en) begin
      stg[0] <= '{valid: i_valid, data: i_data};
      for (int k = 1; k < MAX_DELAY; k++) stg[k] <= stg[k-1];
    end
  end

  // Active delay register: changes only on load, independent of the enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          dly_q <= DLY_RST;
    else if (i_delay_load) dly_q <= dly_new;
  end

  // Fill counter: restarts on load, counts enabled steps, saturates at the delay.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    fill_cnt <= '0;
    else if (i_delay_load)           fill_cnt <= '0;
    else if (i_en && fill_cnt < dly_q) fill_cnt <= fill_cnt + CNT_W'(1);
  end

  // Split the struct array into the flat vectors the tap mux takes.
  always_comb begin
    vld_pipe = '0;
    tap_data = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      vld_pipe[k] = stg[k].valid;
      tap_data[k] = stg[k].data;
    end
  end

  delay_tap_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_DELAY  (MAX_DELAY),
    .CNT_W      (CNT_W)
  ) u_tap (
    .tap_valid (vld_pipe),
    .tap_data  (tap_data),
    .sel       (dly_q - CNT_W'(1)),
    .o_valid   (o_valid),
    .o_data    (o_data)
  );

  assign o_delay = dly_q;
  assign o_fill  = (fill_cnt < dly_q);

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: vector table plus hand-written multi-cycle sequences.
module tb_prog_delay_line;

  localparam int DW = 8;
  localparam int MD = 16;
  localparam int DD = 4;
  localparam int CW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_en;
  logic          i_delay_load;
  logic [CW-1:0] i_delay;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_delay;
  logic          o_fill;

  int nvec = 0;
  int nerr = 0;

  prog_delay_line #(.DATA_WIDTH(DW), .MAX_DELAY(MD), .DEFAULT_DELAY(DD)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_delay_load (i_delay_load),
    .i_delay      (i_delay),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_delay      (o_delay),
    .o_fill       (o_fill)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          en;
    logic          ld;
    logic [CW-1:0] dly;
    logic          v;
    logic [DW-1:0] d;
    logic          ev;
    logic          cd;
    logic [DW-1:0] ed;
    logic [CW-1:0] edly;
    logic          efill;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Apply one set of inputs across one rising edge, leave time at edge+1.
  task automatic drive(input logic en, input logic ld, input logic [CW-1:0] d,
                       input logic v, input logic [DW-1:0] dt);
    i_en = en; i_delay_load = ld; i_delay = d; i_valid = v; i_data = dt;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int acc[16];
    int si;
    int estep;
    logic ev;
    logic [DW-1:0] ed;
    logic en;

    //            en ld dly v  d       ev cd ed      edly efill
    tbl[0]  = '{1, 0, 0,  1, 8'h01, 0, 0, 8'h00, 4,  1};
    tbl[1]  = '{1, 0, 0,  1, 8'h02, 0, 0, 8'h00, 4,  1};
    tbl[2]  = '{1, 0, 0,  1, 8'h03, 0, 0, 8'h00, 4,  1};
    tbl[3]  = '{1, 0, 0,  0, 8'h00, 1, 1, 8'h01, 4,  0};
    tbl[4]  = '{1, 0, 0,  0, 8'h00, 1, 1, 8'h02, 4,  0};
    tbl[5]  = '{1, 0, 0,  0, 8'h00, 1, 1, 8'h03, 4,  0};
    tbl[6]  = '{1, 0, 0,  0, 8'h00, 0, 1, 8'h00, 4,  0};
    tbl[7]  = '{1, 0, 0,  1, 8'hA1, 0, 0, 8'h00, 4,  0};
    tbl[8]  = '{1, 0, 0,  0, 8'hB2, 0, 0, 8'h00, 4,  0};
    tbl[9]  = '{1, 0, 0,  1, 8'hC3, 0, 0, 8'h00, 4,  0};
    tbl[10] = '{1, 0, 0,  0, 8'h00, 1, 1, 8'hA1, 4,  0};
    tbl[11] = '{1, 0, 0,  0, 8'h00, 0, 1, 8'hB2, 4,  0};
    tbl[12] = '{1, 0, 0,  0, 8'h00, 1, 1, 8'hC3, 4,  0};
    tbl[13] = '{1, 1, 0,  1, 8'hAA, 0, 1, 8'h00, 1,  1};
    tbl[14] = '{1, 0, 0,  1, 8'h55, 1, 1, 8'h55, 1,  0};
    tbl[15] = '{0, 0, 0,  1, 8'h66, 1, 1, 8'h55, 1,  0};
    tbl[16] = '{1, 0, 0,  0, 8'h66, 0, 1, 8'h66, 1,  0};
    tbl[17] = '{1, 1, 20, 1, 8'h77, 0, 0, 8'h00, 16, 1};

    // Reset state
    i_rst_n = 1'b0; i_en = 0; i_delay_load = 0; i_delay = '0; i_valid = 0; i_data = '0;
    #12;
    chk("rst o_valid", o_valid, 0);
    chk("rst o_data",  o_data,  0);
    chk("rst o_delay", o_delay, DD);
    chk("rst o_fill",  o_fill,  1);
    i_rst_n = 1'b1;

    // Table: fill after reset, basic latency, bubbles, load-0 clamp, stall, load-20 clamp
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].en, tbl[i].ld, tbl[i].dly, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d o_valid", i), o_valid, tbl[i].ev);
      if (tbl[i].cd) chk($sformatf("tbl%0d o_data", i), o_data, tbl[i].ed);
      chk($sformatf("tbl%0d o_delay", i), o_delay, tbl[i].edly);
      chk($sformatf("tbl%0d o_fill", i), o_fill, tbl[i].efill);
    end

    // Stall mid-stream at D=4: no gap, loss or repeat; outputs frozen while stalled
    drive(1, 1, 4, 0, 8'h00);
    chk("t3 o_delay", o_delay, 4);
    si = 0; estep = 0; ev = 0; ed = '0;
    for (int c = 0; c < 30; c++) begin
      en = !(c >= 6 && c <= 8);
      if (en && si < 16) begin
        acc[si] = estep + 1;
        drive(1, 0, 0, 1, 8'(8'h10 + si));
        si++;
      end else if (en) begin
        drive(1, 0, 0, 0, 8'h00);
      end else begin
        drive(0, 0, 0, 1, 8'hEE);
      end
      if (en) begin
        estep++;
        ev = 0;
        for (int j = 0; j < si; j++)
          if (acc[j] == estep - 3) begin ev = 1; ed = 8'(8'h10 + j); end
      end
      chk($sformatf("t3 c%0d o_valid", c), o_valid, ev);
      if (ev) chk($sformatf("t3 c%0d o_data", c), o_data, ed);
      chk($sformatf("t3 c%0d o_fill", c), o_fill, (estep < 4));
    end

    // Mid-stream load of 16; the sample on the load edge is discarded
    for (int k = 0; k < 6; k++) drive(1, 0, 0, 1, 8'(8'h30 + k));
    chk("t4 pre o_valid", o_valid, 1);
    chk("t4 pre o_data",  o_data,  8'h32);
    drive(1, 1, 16, 1, 8'h3F);
    chk("t4 ld o_delay", o_delay, 16);
    chk("t4 ld o_valid", o_valid, 0);
    chk("t4 ld o_fill",  o_fill,  1);
    for (int k = 1; k <= 20; k++) begin
      drive(1, 0, 0, 1, 8'(8'h40 + k - 1));
      chk($sformatf("t4 k%0d o_valid", k), o_valid, (k >= 16));
      chk($sformatf("t4 k%0d o_fill", k),  o_fill,  (k < 16));
      if (k >= 16) chk($sformatf("t4 k%0d o_data", k), o_data, 8'(8'h40 + k - 16));
    end

    // Load during stall: flush happens, line stays frozen
    drive(0, 1, 2, 1, 8'hEE);
    chk("t5 sl o_delay", o_delay, 2);
    chk("t5 sl o_valid", o_valid, 0);
    chk("t5 sl o_fill",  o_fill,  1);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 1, 8'hEE);
      chk($sformatf("t5 st%0d o_valid", k), o_valid, 0);
      chk($sformatf("t5 st%0d o_fill", k),  o_fill,  1);
    end
    drive(1, 0, 0, 1, 8'h90);
    chk("t5 e1 o_valid", o_valid, 0);
    chk("t5 e1 o_fill",  o_fill,  1);
    drive(1, 0, 0, 0, 8'h00);
    chk("t5 e2 o_valid", o_valid, 1);
    chk("t5 e2 o_data",  o_data,  8'h90);
    chk("t5 e2 o_fill",  o_fill,  0);

    // Asynchronous reset between edges, mid-stream
    drive(1, 0, 0, 1, 8'hC0);
    drive(1, 0, 0, 1, 8'hC1);
    chk("t6 pre o_valid", o_valid, 1);
    chk("t6 pre o_data",  o_data,  8'hC0);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("t6 rst o_valid", o_valid, 0);
    chk("t6 rst o_data",  o_data,  0);
    chk("t6 rst o_delay", o_delay, DD);
    chk("t6 rst o_fill",  o_fill,  1);
    #1;
    i_rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, 0, 0, 8'h00);
      chk($sformatf("t6 k%0d o_valid", k), o_valid, 0);
      chk($sformatf("t6 k%0d o_data", k),  o_data,  0);
      chk($sformatf("t6 k%0d o_fill", k),  o_fill,  (k < 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
